// File: rtl/seven_segment_led_pkg.sv
// rtl/seven_segment_led_pkg.sv - shared hex-to-segment table and blank code
package seven_segment_led_pkg;

  typedef logic [6:0] seg_t;

  // Active-low cathode pattern with every segment dark
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_segment_led_if.sv
// rtl/seven_segment_led_if.sv - display value/mask inputs and anode/cathode outputs
interface seven_segment_led_if;

  logic [31:0] NUMBER;
  logic [7:0]  AN_MASK;
  logic [7:0]  AN;
  logic [6:0]  SEG;

  // The master supplies the value to show and observes the display pins
  modport master (
    output NUMBER,
    output AN_MASK,
    input  AN,
    input  SEG
  );

  // The display driver consumes the value and drives the pins
  modport slave (
    input  NUMBER,
    input  AN_MASK,
    output AN,
    output SEG
  );

endinterface

// File: rtl/seven_segment_led_hex_to_seg.sv
// rtl/seven_segment_led_hex_to_seg.sv - combinational hex digit to segment decoder
module hex_to_seg
  import seven_segment_led_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  // Straight table lookup; no state
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/seven_segment_led.sv
// rtl/seven_segment_led.sv - 8-digit time-multiplexed seven-segment display driver
module seven_segment_led
  import seven_segment_led_pkg::*;
(
  input  logic               clk,
  input  logic               RESET,
  seven_segment_led_if.slave disp
);

  logic [2:0] idx;
  logic [3:0] nibble;
  seg_t       seg_dec;
  logic [7:0] an_next;
  seg_t       seg_next;
  logic [7:0] an_q;
  seg_t       seg_q;

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (seg_dec)
  );

  // Select the digit for this slot; NUMBER and AN_MASK are used live
  always_comb begin
    nibble   = disp.NUMBER[{idx, 2'b00} +: 4];
    an_next  = ~(8'b1 << idx) | disp.AN_MASK;
    seg_next = disp.AN_MASK[idx] ? SEG_BLANK : seg_dec;
  end

  // Scan counter and registered outputs; reset blanks immediately
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      idx   <= 3'd0;
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      idx   <= idx + 3'd1;
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign disp.AN  = an_q;
  assign disp.SEG = seg_q;

endmodule

// File: tb/tb_seven_segment_led.sv
// tb/tb_seven_segment_led.sv - self-checking bench for seven_segment_led
module tb_seven_segment_led;

  logic clk;
  logic RESET;
  integer total;
  integer bad;
  integer slot;

  seven_segment_led_if disp ();

  seven_segment_led dut (
    .clk   (clk),
    .RESET (RESET),
    .disp  (disp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ref_hex [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [7:0] scan_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] scan_seg [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] let_seg  [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] mask_seg [4] = '{7'h00, 7'h78, 7'h02, 7'h12};

  // Anode pattern for digit d: only digit d lit, unless masked
  function automatic logic [7:0] model_an(input int d, input logic [7:0] mask);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i != d) || mask[i];
    return r;
  endfunction

  // Cathode pattern for digit d of the value, dark if masked
  function automatic logic [6:0] model_seg(input int d, input logic [31:0] num, input logic [7:0] mask);
    int h;
    h = (num / (32'd1 << (4 * d))) % 16;
    if (mask[d]) return 7'h7F;
    return ref_hex[h];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    slot = slot + 1;
  endtask

  // Pulse reset between edges so the next edge drives digit 0
  task automatic restart();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    slot = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    disp.NUMBER = 32'h76543210;
    disp.AN_MASK = 8'h00;
    #1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (disp.AN !== 8'hFF || disp.SEG !== 7'h7F) begin
        bad++;
        $display("FAIL reset_hold edge %0d: AN=%h SEG=%h required AN=ff SEG=7f", k, disp.AN, disp.SEG);
      end
    end
  endtask

  task automatic test_full_scan();
    disp.NUMBER = 32'h76543210;
    disp.AN_MASK = 8'h00;
    RESET = 1'b0;
    slot = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      total++;
      if (disp.AN !== scan_an[k % 8] || disp.SEG !== scan_seg[k % 8]) begin
        bad++;
        $display("FAIL full_scan edge %0d: AN=%h SEG=%h required AN=%h SEG=%h",
                 k + 1, disp.AN, disp.SEG, scan_an[k % 8], scan_seg[k % 8]);
      end
    end
  endtask

  task automatic test_async_reset();
    step();
    step();
    RESET = 1'b1;
    #1;
    total++;
    if (disp.AN !== 8'hFF || disp.SEG !== 7'h7F) begin
      bad++;
      $display("FAIL async_reset: AN=%h SEG=%h required AN=ff SEG=7f", disp.AN, disp.SEG);
    end
    #1;
    RESET = 1'b0;
    slot = 0;
  endtask

  task automatic test_letters();
    step();
    restart();
    disp.NUMBER = 32'hFEDCBA98;
    disp.AN_MASK = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (disp.SEG !== let_seg[k] || disp.AN !== scan_an[k]) begin
        bad++;
        $display("FAIL letters digit %0d: AN=%h SEG=%h required AN=%h SEG=%h",
                 k, disp.AN, disp.SEG, scan_an[k], let_seg[k]);
      end
    end
  endtask

  task automatic test_masking();
    restart();
    disp.NUMBER = 32'h12345678;
    disp.AN_MASK = 8'hF0;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (k < 4) begin
        if (disp.SEG !== mask_seg[k] || disp.AN !== (scan_an[k] | 8'hF0)) begin
          bad++;
          $display("FAIL masking digit %0d: AN=%h SEG=%h required AN=%h SEG=%h",
                   k, disp.AN, disp.SEG, scan_an[k] | 8'hF0, mask_seg[k]);
        end
      end else if (disp.AN !== 8'hFF || disp.SEG !== 7'h7F) begin
        bad++;
        $display("FAIL masking digit %0d: AN=%h SEG=%h required AN=ff SEG=7f", k, disp.AN, disp.SEG);
      end
    end
  endtask

  task automatic test_live_update();
    restart();
    disp.AN_MASK = 8'h00;
    disp.NUMBER = 32'h0;
    for (int k = 0; k < 4; k++) step();
    disp.NUMBER = 32'h0000000F;
    for (int k = 4; k < 12; k++) begin
      logic [6:0] want;
      step();
      want = ((k % 8) == 0) ? 7'h0E : 7'h40;
      total++;
      if (disp.SEG !== want || disp.AN !== scan_an[k % 8]) begin
        bad++;
        $display("FAIL live_update digit %0d: AN=%h SEG=%h required AN=%h SEG=%h",
                 k % 8, disp.AN, disp.SEG, scan_an[k % 8], want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    restart();
    disp.NUMBER = 32'h76543210;
    disp.AN_MASK = 8'h00;
    for (int k = 0; k < 5; k++) step();
    restart();
    step();
    total++;
    if (disp.AN !== 8'hFE || disp.SEG !== 7'h40) begin
      bad++;
      $display("FAIL reset_mid_frame: AN=%h SEG=%h required AN=fe SEG=40", disp.AN, disp.SEG);
    end
  endtask

  task automatic test_reset_with_edge();
    step();
    step();
    @(posedge clk);
    RESET = 1'b1;
    #1;
    total++;
    if (disp.AN !== 8'hFF || disp.SEG !== 7'h7F) begin
      bad++;
      $display("FAIL reset_with_edge: AN=%h SEG=%h required AN=ff SEG=7f", disp.AN, disp.SEG);
    end
    #1;
    RESET = 1'b0;
    slot = 0;
    step();
    total++;
    if (disp.AN !== 8'hFE) begin
      bad++;
      $display("FAIL reset_with_edge_restart: AN=%h required AN=fe", disp.AN);
    end
  endtask

  task automatic test_random();
    logic [31:0] num;
    logic [7:0]  mask;
    logic [7:0]  want_an;
    logic [6:0]  want_seg;
    int          d;
    restart();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 40) == 0) restart();
      num = $urandom;
      mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      disp.NUMBER = num;
      disp.AN_MASK = mask;
      d = slot % 8;
      want_an = model_an(d, mask);
      want_seg = model_seg(d, num, mask);
      step();
      total++;
      if (disp.AN !== want_an || disp.SEG !== want_seg) begin
        bad++;
        $display("FAIL random iter %0d digit %0d: AN=%h SEG=%h required AN=%h SEG=%h",
                 k, d, disp.AN, disp.SEG, want_an, want_seg);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    slot = 0;
    test_reset();
    test_full_scan();
    test_async_reset();
    test_letters();
    test_masking();
    test_live_update();
    test_reset_mid_frame();
    test_reset_with_edge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
